// File: rtl/uart_rx_buffered.sv
// 8N1 UART receiver with an oversampling bit timer and a circular
// FIFO drained through a first-word-fall-through read port.
module uart_rx_buffered #(
    parameter int CLOCK_FREQ  = 50000000,
    parameter int BIT_RATE    = 115200,
    parameter int BUFFER_SIZE = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         rx,
    input  logic                         rd_en,
    input  logic                         clr_err,
    output logic [7:0]                   rd_data,
    output logic                         empty,
    output logic                         full,
    output logic [$clog2(BUFFER_SIZE):0] count,
    output logic                         frame_error,
    output logic                         overrun
);

    localparam int CLKS_PER_BIT = CLOCK_FREQ / BIT_RATE;
    localparam int AW           = $clog2(BUFFER_SIZE);

    localparam logic [15:0]   HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0]   BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   DEPTH     = (AW + 1)'(BUFFER_SIZE);
    localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_e;

    logic          rx_meta_q;
    logic          rx_s_q;
    logic          rx_d_q;

    state_e        state_q;
    logic [15:0]   timer_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shift_q;

    logic [7:0]    mem_q [BUFFER_SIZE];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    logic          frame_error_q;
    logic          overrun_q;

    logic          stop_hit;
    logic          frame_ok;
    logic          frame_bad;
    logic          pop;
    logic          push;
    logic          drop;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_d_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            rx_d_q    <= rx_s_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            timer_q   <= 16'd0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    timer_q <= 16'd0;
                    if (rx_d_q && !rx_s_q) begin
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    if (timer_q == HALF_LAST) begin
                        timer_q   <= 16'd0;
                        bit_idx_q <= 3'd0;
                        // A line back high at mid-start is a glitch
                        state_q   <= rx_s_q ? S_IDLE : S_DATA;
                    end else begin
                        timer_q <= timer_q + 16'd1;
                    end
                end
                S_DATA: begin
                    if (timer_q == BIT_LAST) begin
                        timer_q   <= 16'd0;
                        shift_q   <= {rx_s_q, shift_q[7:1]};
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= S_STOP;
                        end
                    end else begin
                        timer_q <= timer_q + 16'd1;
                    end
                end
                S_STOP: begin
                    if (timer_q == BIT_LAST) begin
                        timer_q <= 16'd0;
                        state_q <= S_IDLE;
                    end else begin
                        timer_q <= timer_q + 16'd1;
                    end
                end
                default: begin
                    timer_q <= 16'd0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign stop_hit  = (state_q == S_STOP) && (timer_q == BIT_LAST);
    assign frame_ok  = stop_hit && rx_s_q;
    assign frame_bad = stop_hit && !rx_s_q;

    // Fullness is judged after a same-cycle pop
    assign pop  = rd_en && (count_q != '0);
    assign push = frame_ok && ((count_q != DEPTH) || pop);
    assign drop = frame_ok && !push;

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_error_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            if (frame_bad) begin
                frame_error_q <= 1'b1;
            end else if (clr_err) begin
                frame_error_q <= 1'b0;
            end
            if (drop) begin
                overrun_q <= 1'b1;
            end else if (clr_err) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign rd_data     = mem_q[rd_ptr_q];
    assign empty       = (count_q == '0);
    assign full        = (count_q == DEPTH);
    assign count       = count_q;
    assign frame_error = frame_error_q;
    assign overrun     = overrun_q;

endmodule
